// File: rtl/parking_occupancy_tracker.sv
// Two-floor parking occupancy map driven by debounced arrive/depart buttons.
// Each button: 2-flop synchronizer -> LOW/HIGH debounce FSM -> rising-edge pulse.
// Pulses commit a depart-then-arrive update to the 16-bit map and report errors.
module parking_occupancy_tracker #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned DB_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive,
    input  logic [3:0] arr_floor,
    input  logic [3:0] arr_spot,
    input  logic       depart,
    input  logic [3:0] dep_floor,
    input  logic [3:0] dep_spot,
    output logic [7:0] f,
    output logic [7:0] g,
    output logic [4:0] free_cnt,
    output logic       full,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic {LOW, HIGH} db_state_t;

    // Button index 0 = arrive, 1 = depart.
    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    db_state_t       state      [2];
    db_state_t       state_next [2];
    db_state_t       state_prev [2];
    logic [DB_W-1:0] cnt        [2];
    logic [DB_W-1:0] cnt_next   [2];
    logic [1:0]      ev;

    logic [15:0] map;
    logic [15:0] map_mid;
    logic [15:0] map_next;
    logic        arr_legal;
    logic        dep_legal;
    logic [3:0]  arr_idx;
    logic [3:0]  dep_idx;
    logic        arr_bad;
    logic        dep_bad;
    logic [4:0]  free_next;

    assign raw = {depart, arrive};

    // Two-flop synchronizer for the raw buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce state/counter registers and the LOW->HIGH edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < 2; b++) begin
                state[b]      <= LOW;
                state_prev[b] <= LOW;
                cnt[b]        <= '0;
            end
            ev <= '0;
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                state[b]      <= state_next[b];
                state_prev[b] <= state[b];
                cnt[b]        <= cnt_next[b];
                ev[b]         <= (state[b] == HIGH) && (state_prev[b] == LOW);
            end
        end
    end

    // Debounce next-state: count while level differs, toggle after DB_CYCLES.
    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            state_next[b] = state[b];
            cnt_next[b]   = '0;
            if ((state[b] == HIGH) != sync2[b]) begin
                if (cnt[b] == DB_W'(DB_CYCLES - 1)) begin
                    state_next[b] = (state[b] == HIGH) ? LOW : HIGH;
                end else begin
                    cnt_next[b] = cnt[b] + DB_W'(1);
                end
            end
        end
    end

    // Map update: depart applied to the current map, arrive to the post-depart map.
    always_comb begin
        dep_legal = ((dep_floor == 4'b0001) || (dep_floor == 4'b0010)) &&
                    (dep_spot >= 4'd1) && (dep_spot <= 4'd8);
        arr_legal = ((arr_floor == 4'b0001) || (arr_floor == 4'b0010)) &&
                    (arr_spot >= 4'd1) && (arr_spot <= 4'd8);
        dep_idx   = {dep_floor == 4'b0010, 3'(dep_spot - 4'd1)};
        arr_idx   = {arr_floor == 4'b0010, 3'(arr_spot - 4'd1)};
        map_mid   = map;
        dep_bad   = 1'b0;
        arr_bad   = 1'b0;
        if (ev[1]) begin
            if (dep_legal && map[dep_idx]) begin
                map_mid[dep_idx] = 1'b0;
            end else begin
                dep_bad = 1'b1;
            end
        end
        map_next = map_mid;
        if (ev[0]) begin
            if (arr_legal && !map_mid[arr_idx]) begin
                map_next[arr_idx] = 1'b1;
            end else begin
                arr_bad = 1'b1;
            end
        end
        free_next = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!map_next[i]) begin
                free_next = free_next + 5'd1;
            end
        end
    end

    // Registered map, free count, full flag and error reporting.
    always_ff @(posedge clk) begin
        if (reset) begin
            map      <= '0;
            free_cnt <= 5'd16;
            full     <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            map      <= map_next;
            free_cnt <= free_next;
            full     <= (free_next == 5'd0);
            err      <= arr_bad | dep_bad;
            if (arr_bad | dep_bad) begin
                err_code <= {dep_bad, arr_bad};
            end
        end
    end

    assign f = map[7:0];
    assign g = map[15:8];

endmodule

// File: doc/parking_occupancy_tracker.md
# parking_occupancy_tracker

Sequential owner of the two-floor parking occupancy map. It accepts debounced "car parked" (arrive) and "car left" (depart) button events, each tagged with a floor/spot code. It updates the 16 occupancy bits and drives them as `f[7:0]` / `g[7:0]` into the spot-finder logic. It also reports the free-spot count, a full flag and error pulses for illegal events.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable cycles required by the debounce filter (10 ms at 50 MHz); must be ≥1.
- `DB_W`, default 20: debounce counter width; must satisfy 2^DB_W > DB_CYCLES.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `arrive`  in  1  raw, asynchronous, bouncing button: car has parked at `arr_floor`/`arr_spot`.
- `arr_floor`  in  4  floor code: 4'b0001 = floor 1 (`f`), 4'b0010 = floor 2 (`g`).
- `arr_spot`  in  4  spot code 4'b0001..4'b1000 → bit index spot-1.
- `depart`  in  1  raw button: car has left `dep_floor`/`dep_spot`.
- `dep_floor`  in  4  same encoding as `arr_floor`.
- `dep_spot`  in  4  same encoding as `arr_spot`.
- `f`  out  8  floor-1 occupancy, 1 = occupied; reset 8'h00.
- `g`  out  8  floor-2 occupancy; reset 8'h00.
- `free_cnt`  out  5  number of zero bits in {g,f}; reset 5'd16.
- `full`  out  1  free_cnt == 0; reset 0.
- `err`  out  1  one-cycle pulse on an illegal event; reset 0.
- `err_code`  out  2  01 = bad arrive, 10 = bad depart, 11 = both; holds last value; reset 2'b00.

## Operation
- Each button has its own path: 2-flop synchronizer → debounce FSM → rising-edge detector → one-cycle event pulse (`arr_ev`, `dep_ev`).
- Debounce FSM per button:
  - States: LOW and HIGH, plus a DB_W-bit counter.
  - While the synchronized level equals the state, the counter is held at 0.
  - While it differs, the counter increments by 1 per cycle.
  - When the counter reaches DB_CYCLES-1 and the level still differs, the state toggles and the counter clears.
  - Any single-cycle return to the state level clears the counter.
- Event pulse: asserted for exactly one cycle after the LOW→HIGH transition. HIGH→LOW produces nothing. Holding the button produces exactly one event.
- Commit: in the cycle the event pulse is high, the floor/spot inputs are sampled and the occupancy update is registered.
- Legal spot code: floor ∈ {0001, 0010} and spot ∈ {0001..1000}. Any other code, including the 4'b1000/4'b1000 "no spot" code, is illegal.
- Arrive:
  - Legal code on an empty bit → set the bit.
  - Illegal code or an already-occupied bit → no change, `err` pulse, `err_code` bit0 set.
- Depart:
  - Legal code on an occupied bit → clear the bit.
  - Illegal code or an already-empty bit → no change, `err` pulse, `err_code` bit1 set.
- Simultaneous arrive and depart in the same cycle:
  - Depart is evaluated first against the current map; arrive is then evaluated against the post-depart map. Both apply in one cycle.
  - Same spot in both: the depart clears it, the arrive re-sets it. The bit stays 1, `free_cnt` is unchanged, no error.
  - If both are illegal, `err_code` = 11.
- `free_cnt` and `full` are registered and computed from the next-state map, so they update in the same cycle as `f`/`g`. Range is 0..16, with no wrap: a full map rejects arrives via the occupied check.

## Timing
- Raw edge to event pulse: the input is sampled by sync flop 1 at edge n, sync2 at n+1, the debounce state toggles at n+1+DB_CYCLES, and the event pulse is high in the cycle after edge n+2+DB_CYCLES.
- `f`/`g`/`free_cnt`/`full`/`err` change at edge n+3+DB_CYCLES.
- Total latency: DB_CYCLES+3 edges from first sampling of a stable input.
- Floor/spot inputs must be stable during the pulse cycle; they are don't-care otherwise.
- `err` is high for exactly one cycle per illegal commit.
- Reset:
  - Reset synchronously clears everything: sync flops, FSMs to LOW, counters, map, `err`, `err_code`, and sets `free_cnt` to 16.
  - An event pulse coincident with reset is discarded.
  - A button still held after reset release produces one event after the normal latency.

## Test plan
- `DB_CYCLES`=2 for all scenarios. Apply reset, then arrive with floor 0001 / spot 0011, held clean → `f`=8'h04 exactly 5 edges after first sampling, `free_cnt`=15, `err`=0.
- Arrive with bounce high/low/high/low/high, each level 1 cycle, then held → no event until 2 stable cycles; exactly one set bit total.
- Fill all 16 spots → `full`=1 and `free_cnt`=0. A 17th arrive at floor 0010 / spot 1000 → `err` 1-cycle pulse, `err_code`=01, map unchanged.
- Depart floor 0010 / spot 0001 on an empty map → `err`=1, `err_code`=10. Arrive with code 1000/1000 → `err`=1, `err_code`=01, `free_cnt`=16.
- With `f`=8'h01, arrive and depart on floor 0001 / spot 0001 in the same pulse cycle → `f`=8'h01, `free_cnt`=15, no error. Arrive at floor 1 / spot 2 while departing floor 1 / spot 1 → `f`=8'h02.
- Assert reset mid-debounce and in the pulse cycle → no map change, outputs at reset values. Button held through reset release → one event after the full latency.
